// File: rtl/gn_pkg.sv
// Shared types and width helpers for the group-norm statistics controller.
package gn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_CALC,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Default geometry: 8x8 pixels, 16 channels per group -> 1024 samples per group.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N          = 8 * 8 * 16;
    localparam int LOG2N          = $clog2(DEF_N);

    // Sum of N samples needs LOG2N extra bits over the sample width.
    function automatic int sumWidth(input int dataWidth, input int log2n);
        return dataWidth + log2n;
    endfunction

    // Sum of N squared samples needs LOG2N extra bits over the square width.
    function automatic int sumsqWidth(input int dataWidth, input int log2n);
        return 2 * dataWidth + log2n;
    endfunction

    // Variance of unsigned samples fits in twice the sample width.
    function automatic int varWidth(input int dataWidth);
        return 2 * dataWidth;
    endfunction

    // True when n is a non-zero power of two.
    function automatic bit isPow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/gn_stat_acc.sv
// Running sum / sum-of-squares for one group and the mean/variance reduction.
module gn_stat_acc
    import gn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LOG2N_P    = LOG2N
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear_i,
    input  logic                            acc_en_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            calc_en_i,
    output logic [DATA_WIDTH-1:0]           mean_o,
    output logic [varWidth(DATA_WIDTH)-1:0] var_o
);

    localparam int SW  = sumWidth(DATA_WIDTH, LOG2N_P);
    localparam int SQW = sumsqWidth(DATA_WIDTH, LOG2N_P);
    localparam int VW  = varWidth(DATA_WIDTH);

    logic [SW-1:0]         sum_q;
    logic [SQW-1:0]        sumsq_q;
    logic [DATA_WIDTH-1:0] mean_q;
    logic [VW-1:0]         var_q;

    logic [DATA_WIDTH-1:0] mean_d;
    logic [VW-1:0]         sqAvg;
    logic [VW-1:0]         meanSq;
    logic [VW-1:0]         var_d;

    // Accumulate each accepted sample; clearing wins so a transfer or abort starts a clean group.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            sum_q   <= '0;
            sumsq_q <= '0;
        end else if (acc_en_i) begin
            sum_q   <= sum_q + SW'(data_i);
            sumsq_q <= sumsq_q + (SQW'(data_i) * SQW'(data_i));
        end
    end

    // Floor mean and floor variance from the group totals; a negative difference clamps to zero.
    always_comb begin
        mean_d = DATA_WIDTH'(sum_q >> LOG2N_P);
        sqAvg  = VW'(sumsq_q >> LOG2N_P);
        meanSq = VW'(mean_d) * VW'(mean_d);
        var_d  = (sqAvg >= meanSq) ? (sqAvg - meanSq) : '0;
    end

    // Capture the statistics during the single calculation cycle and hold them for the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            mean_q <= '0;
            var_q  <= '0;
        end else if (calc_en_i) begin
            mean_q <= mean_d;
            var_q  <= var_d;
        end
    end

    assign mean_o = mean_q;
    assign var_o  = var_q;

endmodule

// File: rtl/gn_stat_ctrl.sv
// Group-norm statistics controller: counts samples into groups and hands mean/variance to the normalizer.
module gn_stat_ctrl
    import gn_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int IMG_WIDTH        = 8,
    parameter int IMG_HEIGHT       = 8,
    parameter int CHANNEL_NUM      = 64,
    parameter int CHANNEL_IN_GROUP = 16,
    localparam int GROUP_NUM       = CHANNEL_NUM / CHANNEL_IN_GROUP,
    localparam int GW              = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            end_of_frame,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            cfg_valid,
    input  logic                            cfg_ready,
    output logic [GW-1:0]                   cfg_group,
    output logic [DATA_WIDTH-1:0]           cfg_mean,
    output logic [varWidth(DATA_WIDTH)-1:0] cfg_var,
    output logic                            frame_done,
    output logic                            frame_err
);

    localparam int N       = IMG_WIDTH * IMG_HEIGHT * CHANNEL_IN_GROUP;
    localparam int GRP_L2N = $clog2(N);

    if (!isPow2(N) || (GRP_L2N < 1)) begin : g_bad_group_size
        $error("gn_stat_ctrl: samples per group must be a power of two of at least 2");
    end
    if ((GROUP_NUM < 1) || ((CHANNEL_NUM % CHANNEL_IN_GROUP) != 0)) begin : g_bad_group_count
        $error("gn_stat_ctrl: CHANNEL_NUM must be a non-zero multiple of CHANNEL_IN_GROUP");
    end

    state_t             state_q;
    logic [GRP_L2N-1:0] cnt_q;
    logic [GW-1:0]      group_q;
    logic               cfg_valid_q;
    logic               frame_done_q;
    logic               frame_err_q;

    logic accept;
    logic lastSample;
    logic lastGroup;
    logic eofError;
    logic accEn;
    logic accClear;
    logic calcEn;

    // Handshake and termination decode shared by the FSM and the accumulator.
    always_comb begin
        in_ready   = !reset && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
        accept     = in_valid && in_ready;
        lastSample = &cnt_q;
        lastGroup  = (group_q == GW'(GROUP_NUM - 1));
        eofError   = (state_q == ST_ACCUM) && end_of_frame &&
                     !(accept && lastSample && lastGroup);
        accEn      = accept && !eofError;
        accClear   = eofError || ((state_q == ST_EMIT) && cfg_ready);
        calcEn     = (state_q == ST_CALC);
    end

    // Frame sequencing: accumulate a group, reduce it, present it, then advance or finish the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            group_q      <= '0;
            cfg_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q   <= cnt_q + GRP_L2N'(1);
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (eofError) begin
                        cnt_q       <= '0;
                        group_q     <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (accept) begin
                        cnt_q <= cnt_q + GRP_L2N'(1);
                        if (lastSample) begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cfg_valid_q <= 1'b1;
                    state_q     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (cfg_ready) begin
                        cfg_valid_q <= 1'b0;
                        if (lastGroup) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            group_q <= group_q + GW'(1);
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    group_q <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    gn_stat_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2N_P    (GRP_L2N)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accClear),
        .acc_en_i  (accEn),
        .data_i    (in_data),
        .calc_en_i (calcEn),
        .mean_o    (cfg_mean),
        .var_o     (cfg_var)
    );

    assign cfg_valid  = cfg_valid_q;
    assign cfg_group  = group_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_gn_stat_ctrl.sv
// Scoreboard bench for gn_stat_ctrl with a plain-arithmetic reference model of group statistics.
module tb_gn_stat_ctrl;

    localparam int DW     = 8;
    localparam int N      = 1024;
    localparam int GROUPS = 4;
    localparam int FRAME  = N * GROUPS;

    logic          clk = 1'b0;
    logic          reset;
    logic          end_of_frame;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_group;
    logic [DW-1:0] cfg_mean;
    logic [15:0]   cfg_var;
    logic          frame_done;
    logic          frame_err;

    typedef struct {
        int grp;
        int mean;
        int varv;
    } exp_t;

    exp_t expQ[$];

    int     checksTotal  = 0;
    int     checksPassed = 0;
    int     expDone      = 0;
    int     expErr       = 0;
    int     readyMode    = 0;
    int     stallCnt     = 0;
    bit     monEnable    = 0;
    bit     aborted      = 0;

    int     mGroup = 0;
    int     mCount = 0;
    longint mSum   = 0;
    longint mSq    = 0;

    gn_stat_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .end_of_frame (end_of_frame),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_group    (cfg_group),
        .cfg_mean     (cfg_mean),
        .cfg_var      (cfg_var),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checksTotal++;
        if (actual == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelClear();
        mGroup = 0;
        mCount = 0;
        mSum   = 0;
        mSq    = 0;
    endtask

    // Reference: a group's statistics are floor(sum/N) and max(0, floor(sumsq/N) - mean^2).
    task automatic modelAccept(input int x, input bit eof);
        exp_t e;
        bit   frameActive;
        frameActive = (mCount > 0) || (mGroup > 0);
        if (eof && frameActive && !((mCount == N - 1) && (mGroup == GROUPS - 1))) begin
            expErr++;
            modelClear();
            return;
        end
        mSum += x;
        mSq  += x * x;
        mCount++;
        if (mCount == N) begin
            e.grp  = mGroup;
            e.mean = int'(mSum / N);
            e.varv = int'(mSq / N) - e.mean * e.mean;
            if (e.varv < 0) e.varv = 0;
            expQ.push_back(e);
            mCount = 0;
            mSum   = 0;
            mSq    = 0;
            if (mGroup == GROUPS - 1) begin
                mGroup = 0;
                expDone++;
            end else begin
                mGroup++;
            end
        end
    endtask

    // Offer one sample and wait (bounded) for it to be accepted; called at posedge+1.
    task automatic applyStimulus(input int x, input bit eof, input bit gaps);
        int waitCycles;
        if (aborted) return;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid     = 1'b1;
        in_data      = x[DW-1:0];
        end_of_frame = eof;
        waitCycles   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitCycles++;
            if (waitCycles > 200) begin
                checksTotal++;
                $display("[TB] FAIL in_ready timeout: still 0 after %0d cycles, expected 1", waitCycles);
                aborted      = 1;
                in_valid     = 1'b0;
                end_of_frame = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        end_of_frame = 1'b0;
        modelAccept(x, eof);
    endtask

    task automatic pulseEof(input bit expectErr);
        end_of_frame = 1'b1;
        in_valid     = 1'b0;
        @(posedge clk);
        #1;
        end_of_frame = 1'b0;
        if (expectErr) begin
            expErr++;
            modelClear();
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 4000; i++) begin
            if (expQ.size() == 0 && expDone == 0 && expErr == 0) break;
            @(negedge clk);
        end
        checkOutput("pending cfg entries", expQ.size(), 0);
        checkOutput("pending frame_done", expDone, 0);
        checkOutput("pending frame_err", expErr, 0);
        @(posedge clk);
        #1;
    endtask

    // Normalizer side: always ready, random, a 10-cycle stall per group, or never ready.
    initial begin
        cfg_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: cfg_ready = 1'b1;
                1: cfg_ready = $urandom_range(0, 1) == 1;
                2: begin
                    if (!cfg_valid) begin
                        stallCnt  = 0;
                        cfg_ready = 1'b1;
                    end else if (stallCnt < 10) begin
                        stallCnt++;
                        cfg_ready = 1'b0;
                    end else begin
                        cfg_ready = 1'b1;
                    end
                end
                default: cfg_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each cfg transfer and checks hold-stability and pulses.
    logic [1:0]    prevGroup;
    logic [DW-1:0] prevMean;
    logic [15:0]   prevVar;
    bit            prevStall = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset || !monEnable) begin
            prevStall = 0;
        end else begin
            if (prevStall) begin
                checkOutput("cfg_valid held while stalled", cfg_valid, 1);
                checkOutput("cfg_group stable", cfg_group, prevGroup);
                checkOutput("cfg_mean stable", cfg_mean, prevMean);
                checkOutput("cfg_var stable", cfg_var, prevVar);
            end
            if (cfg_valid) begin
                checkOutput("in_ready low while presenting", in_ready, 0);
            end
            if (cfg_valid && cfg_ready) begin
                if (expQ.size() == 0) begin
                    checksTotal++;
                    $display("[TB] FAIL unexpected cfg transfer: group %0d, expected none", cfg_group);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("cfg_group", cfg_group, e.grp);
                    checkOutput("cfg_mean", cfg_mean, e.mean);
                    checkOutput("cfg_var", cfg_var, e.varv);
                end
            end
            if (frame_done) begin
                checkOutput("frame_done expected", expDone > 0, 1);
                checkOutput("all groups sent at frame_done", expQ.size(), 0);
                if (expDone > 0) expDone--;
            end
            if (frame_err) begin
                checkOutput("frame_err expected", expErr > 0, 1);
                checkOutput("cfg_valid low at frame_err", cfg_valid, 0);
                if (expErr > 0) expErr--;
            end
            prevStall = cfg_valid && !cfg_ready;
            prevGroup = cfg_group;
            prevMean  = cfg_mean;
            prevVar   = cfg_var;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " in_ready"}, in_ready, 0);
        checkOutput({tag, " cfg_valid"}, cfg_valid, 0);
        checkOutput({tag, " cfg_group"}, cfg_group, 0);
        checkOutput({tag, " cfg_mean"}, cfg_mean, 0);
        checkOutput({tag, " cfg_var"}, cfg_var, 0);
        checkOutput({tag, " frame_done"}, frame_done, 0);
        checkOutput({tag, " frame_err"}, frame_err, 0);
    endtask

    // Main sequence of frames covering uniform, alternating, saturated, aborted and random data.
    initial begin
        bit reached;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        end_of_frame = 1'b0;
        modelClear();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset     = 1'b0;
        monEnable = 1;
        @(negedge clk);
        checkOutput("in_ready after reset", in_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] end_of_frame alone while idle");
        pulseEof(0);

        $display("[TB] frame of constant 5");
        readyMode = 0;
        for (int i = 0; i < FRAME; i++) applyStimulus(5, 0, 0);
        waitIdle();

        $display("[TB] frame alternating 0/10 with random cfg_ready");
        readyMode = 1;
        for (int i = 0; i < FRAME; i++) applyStimulus((i % 2) ? 10 : 0, 0, 0);
        waitIdle();

        $display("[TB] frame of 255 with 10-cycle stalls, end_of_frame on last sample");
        readyMode = 2;
        for (int i = 0; i < FRAME; i++) applyStimulus(255, i == FRAME - 1, 0);
        waitIdle();

        $display("[TB] early end_of_frame on 100th sample");
        readyMode = 0;
        for (int i = 0; i < 100; i++) applyStimulus($urandom_range(0, 255), i == 99, 0);
        @(negedge clk);
        checkOutput("in_ready after abort", in_ready, 1);
        @(posedge clk);
        #1;
        waitIdle();

        $display("[TB] end_of_frame alone mid-group");
        for (int i = 0; i < 50; i++) applyStimulus($urandom_range(0, 255), 0, 0);
        pulseEof(1);
        waitIdle();

        $display("[TB] random frame with gaps and random cfg_ready");
        readyMode = 1;
        for (int i = 0; i < FRAME; i++) applyStimulus($urandom_range(0, 255), i == FRAME - 1, 1);
        waitIdle();

        $display("[TB] reset while presenting group 2");
        readyMode = 0;
        for (int i = 0; i < 2 * N + 1; i++) applyStimulus($urandom_range(0, 255), 0, 0);
        readyMode = 3;
        for (int i = 1; i < N; i++) applyStimulus($urandom_range(0, 255), 0, 0);
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cfg_valid) begin
                reached = 1;
                break;
            end
        end
        checkOutput("group 2 presented", reached, 1);
        checkOutput("presented group index", cfg_group, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        modelClear();
        @(posedge clk);
        @(negedge clk);
        checkAllZero("mid-emit reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] fresh random frame after reset");
        readyMode = 1;
        for (int i = 0; i < FRAME; i++) applyStimulus($urandom_range(0, 255), 0, 0);
        waitIdle();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
